spu_logic_lut: RTL and testbench

- Multi-lane, 3-input configurable logic unit with valid tracking and optional stream reduction (AND/OR/XOR accumulate over a frame).
- Each bit is computed from an 8-entry truth table, so any 3-input Boolean function is available.
- Configuration is double-buffered and commits only at frame boundaries.
- Sits in the SPU datapath between SRAM read ports and downstream SPU stages.

---
 rtl/spu_logic_pkg.sv | 28 ++
 rtl/spu_data.sv | 29 ++
 rtl/spu_logic_lut.sv | 136 +++++++++++++
 tb/tb_spu_logic_lut.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_logic_pkg.sv
// Shared types and constants for the SPU configurable 3-input logic unit.
package spu_logic_pkg;

  // How beats within a frame are combined before reaching the output.
  typedef enum logic [1:0] {
    ACC_BYPASS = 2'b00,
    ACC_AND    = 2'b01,
    ACC_OR     = 2'b10,
    ACC_XOR    = 2'b11
  } acc_mode_t;

  // Common truth tables, indexed by {c,b,a}.
  localparam logic [7:0] LUT_PASS_A = 8'hAA;
  localparam logic [7:0] LUT_AND_AB = 8'h88;
  localparam logic [7:0] LUT_OR_AB  = 8'hEE;
  localparam logic [7:0] LUT_XOR_AB = 8'h66;
  localparam logic [7:0] LUT_MAJ    = 8'hE8;

  localparam int LANE_BITS = 8;
  typedef logic [LANE_BITS-1:0] lane_t;

  // One output bit of the configurable function: the truth-table entry at {c,b,a}.
  function automatic logic lut_bit(input logic [7:0] lut, input logic a,
                                   input logic b, input logic c);
    return lut[{c, b, a}];
  endfunction

endpackage

// File: rtl/spu_data.sv
// Clock-enabled delay line used for the SPU output tail.
module spu_data #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cke,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  // Shift the word one stage per enabled clock.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every stage is reset because it carries the valid bit; an
    // unreset stage could emit a phantom beat right after reset.
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else if (cke) begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/spu_logic_lut.sv
// Multi-lane 3-input LUT logic unit with optional per-frame AND/OR/XOR
// reduction and a double-buffered configuration committed between frames.
module spu_logic_lut
  import spu_logic_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cke,
  input  logic                          cfg_we,
  input  logic [7:0]                    cfg_lut,
  input  logic [1:0]                    cfg_acc,
  output logic                          cfg_pending,
  input  logic                          s_valid,
  input  logic                          s_last,
  input  logic [CHANNELS*DATA_BITS-1:0] s_data0,
  input  logic [CHANNELS*DATA_BITS-1:0] s_data1,
  input  logic [CHANNELS*DATA_BITS-1:0] s_data2,
  output logic                          m_valid,
  output logic                          m_last,
  output logic [CHANNELS*DATA_BITS-1:0] m_data
);

  localparam int W = CHANNELS * DATA_BITS;

  logic [7:0] act_lut_q, pend_lut_q;
  acc_mode_t  act_acc_q, pend_acc_q;
  logic       pend_q;
  logic       in_frame_q;
  logic       in_frame_d;
  logic       commit;
  logic [W-1:0] acc_q;
  logic [W-1:0] y;
  logic [W-1:0] reduced;
  logic         s1_valid_q, s1_last_q;
  logic [W-1:0] s1_data_q;
  logic [W+1:0] tail_q;

  // Stage 0: evaluate the active truth table on every bit of every lane.
  always_comb begin
    y = '0;
    for (int i = 0; i < W; i++) y[i] = lut_bit(act_lut_q, s_data0[i], s_data1[i], s_data2[i]);
  end

  // Fold the current beat into the running frame value; a frame's first beat starts it fresh.
  always_comb begin
    // NOTE: assigning a default before the case keeps this purely
    // combinational; a path that leaves it unassigned would infer a latch.
    reduced = y;
    if (in_frame_q) begin
      case (act_acc_q)
        ACC_AND: reduced = acc_q & y;
        ACC_OR:  reduced = acc_q | y;
        ACC_XOR: reduced = acc_q ^ y;
        default: reduced = y;
      endcase
    end
  end

  // A config may only take effect when no frame remains open after this edge.
  assign in_frame_d = s_valid ? ~s_last : in_frame_q;
  assign commit     = pend_q & ~in_frame_d;

  // Double-buffered configuration: writes land in pending, commit copies to active.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_lut_q  <= LUT_PASS_A;
      act_acc_q  <= ACC_BYPASS;
      pend_lut_q <= LUT_PASS_A;
      pend_acc_q <= ACC_BYPASS;
      pend_q     <= 1'b0;
    end else if (cke) begin
      // NOTE: non-blocking assignment means a commit on the same edge as a
      // write copies the old pending value, while the new write stays pending.
      if (commit) begin
        act_lut_q <= pend_lut_q;
        act_acc_q <= pend_acc_q;
      end
      if (cfg_we) begin
        pend_lut_q <= cfg_lut;
        pend_acc_q <= acc_mode_t'(cfg_acc);
        pend_q     <= 1'b1;
      end else if (commit) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Stage 1: frame tracking, accumulation and the registered beat result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_frame_q <= 1'b0;
      acc_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
    end else if (cke) begin
      in_frame_q <= in_frame_d;
      if (s_valid) begin
        if (act_acc_q == ACC_BYPASS) begin
          s1_valid_q <= 1'b1;
          s1_last_q  <= s_last;
          s1_data_q  <= y;
        end else begin
          acc_q      <= reduced;
          s1_valid_q <= s_last;
          s1_last_q  <= s_last;
          if (s_last) s1_data_q <= reduced;
        end
      end else begin
        s1_valid_q <= 1'b0;
        s1_last_q  <= 1'b0;
      end
    end
  end

  spu_data #(
    .DEPTH (LATENCY - 1),
    .WIDTH (W + 2)
  ) u_tail (
    .clk     (clk),
    .reset_n (reset_n),
    .cke     (cke),
    .d_i     ({s1_valid_q, s1_last_q, s1_data_q}),
    .q_o     (tail_q)
  );

  assign m_valid     = tail_q[W+1];
  assign m_last      = tail_q[W];
  assign m_data      = tail_q[W-1:0];
  assign cfg_pending = pend_q;

endmodule

// File: tb/tb_spu_logic_lut.sv
// Scoreboard bench for spu_logic_lut: randomized and directed beats are fed
// through a frame-level reference model; a monitor compares DUT outputs.
module tb_spu_logic_lut;

  localparam int LATENCY   = 2;
  localparam int DATA_BITS = 8;
  localparam int CHANNELS  = 4;
  localparam int W         = CHANNELS * DATA_BITS;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cke;
  logic         cfg_we;
  logic [7:0]   cfg_lut;
  logic [1:0]   cfg_acc;
  logic         cfg_pending;
  logic         s_valid;
  logic         s_last;
  logic [W-1:0] s_data0, s_data1, s_data2;
  logic         m_valid;
  logic         m_last;
  logic [W-1:0] m_data;

  spu_logic_lut #(
    .LATENCY   (LATENCY),
    .DATA_BITS (DATA_BITS),
    .CHANNELS  (CHANNELS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cke         (cke),
    .cfg_we      (cfg_we),
    .cfg_lut     (cfg_lut),
    .cfg_acc     (cfg_acc),
    .cfg_pending (cfg_pending),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_data0     (s_data0),
    .s_data1     (s_data1),
    .s_data2     (s_data2),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_data      (m_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           at_edge;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] fq[$];

  int n_vec = 0;
  int n_err = 0;
  int en_cnt = 0;
  logic cke_prev = 1'b0;
  logic prev_valid = 1'b0;
  logic [W-1:0] prev_data = '0;

  // Reference model state
  logic [7:0] m_lut, m_plut;
  logic [1:0] m_acc, m_pacc;
  logic       m_pend;
  logic       m_in_frame;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lut_eval(input logic [7:0] lut, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] c);
    logic [W-1:0] r;
    logic [2:0]   idx;
    for (int i = 0; i < W; i++) begin
      idx  = {c[i], b[i], a[i]};
      r[i] = lut[idx];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_lut = 8'hAA; m_acc = 2'b00;
    m_plut = 8'hAA; m_pacc = 2'b00;
    m_pend = 1'b0; m_in_frame = 1'b0;
    fq.delete();
  endtask

  // One enabled clock edge of the behavioural model.
  task automatic model_edge(input logic we, input logic [7:0] lut, input logic [1:0] acc,
                            input logic v, input logic l,
                            input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    logic [W-1:0] y, r;
    logic post;
    exp_t e;
    if (v) begin
      y = lut_eval(m_lut, a, b, c);
      if (m_acc == 2'b00) begin
        e.data = y; e.last = l; e.at_edge = en_cnt + LATENCY;
        sb.push_back(e);
      end else begin
        fq.push_back(y);
        if (l) begin
          r = fq[0];
          for (int i = 1; i < fq.size(); i++) begin
            case (m_acc)
              2'b01:   r = r & fq[i];
              2'b10:   r = r | fq[i];
              default: r = r ^ fq[i];
            endcase
          end
          e.data = r; e.last = 1'b1; e.at_edge = en_cnt + LATENCY;
          sb.push_back(e);
          fq.delete();
        end
      end
    end
    post = v ? !l : m_in_frame;
    m_in_frame = post;
    if (m_pend && !post) begin
      m_lut = m_plut; m_acc = m_pacc; m_pend = 1'b0;
    end
    if (we) begin
      m_plut = lut; m_pacc = acc; m_pend = 1'b1;
    end
  endtask

  task automatic cyc(input logic k, input logic we, input logic [7:0] lut, input logic [1:0] acc,
                     input logic v, input logic l,
                     input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    cke = k; cfg_we = we; cfg_lut = lut; cfg_acc = acc;
    s_valid = v; s_last = l; s_data0 = a; s_data1 = b; s_data2 = c;
    if (k) model_edge(we, lut, acc, v, l, a, b, c);
    @(posedge clk);
    #1;
    check("cfg_pending", {63'd0, cfg_pending}, {63'd0, m_pend});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic beat(input logic l, input logic [W-1:0] a, input logic [W-1:0] b);
    cyc(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, l, a, b, W'($urandom));
  endtask

  task automatic cfg(input logic [7:0] lut, input logic [1:0] acc);
    cyc(1'b1, 1'b1, lut, acc, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic mid_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_last", {63'd0, m_last}, 64'd0);
    check("rst_cfg_pending", {63'd0, cfg_pending}, 64'd0);
    sb.delete();
    model_reset();
    cke = 1'b1; cfg_we = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Count enabled edges so output timing can be checked in enabled cycles.
  always @(posedge clk) begin
    cke_prev <= cke;
    if (cke) en_cnt <= en_cnt + 1;
  end

  // Monitor: compare each presented output beat against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (cke_prev) begin
        if (m_valid) begin
          if (sb.size() == 0) begin
            check("spurious_m_valid", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("m_data", {32'd0, m_data}, {32'd0, e.data});
            check("m_last", {63'd0, m_last}, {63'd0, e.last});
            check("latency_edge", 64'(en_cnt), 64'(e.at_edge));
          end
        end
      end else begin
        check("hold_m_valid", {63'd0, m_valid}, {63'd0, prev_valid});
        check("hold_m_data", {32'd0, m_data}, {32'd0, prev_data});
      end
    end
    prev_valid = m_valid;
    prev_data  = m_data;
  end

  initial begin
    reset_n = 1'b0; cke = 1'b1; cfg_we = 1'b0; cfg_lut = '0; cfg_acc = '0;
    s_valid = 1'b0; s_last = 1'b0; s_data0 = '0; s_data1 = '0; s_data2 = '0;
    model_reset();
    #12;
    check("reset_m_valid", {63'd0, m_valid}, 64'd0);
    check("reset_m_last", {63'd0, m_last}, 64'd0);
    check("reset_m_data", {32'd0, m_data}, 64'd0);
    check("reset_cfg_pending", {63'd0, cfg_pending}, 64'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Default pass-a config, single bypass beat.
    beat(1'b1, 32'h3C3C3C3C, 32'h0F0F0F0F);
    idle(3);

    // XOR of a and b in bypass, committed while idle.
    cfg(8'h66, 2'b00);
    idle(1);
    beat(1'b1, 32'hF0F0F0F0, 32'hFFFFFFFF);
    idle(3);

    // XOR-reduce of pass-a over a three-beat frame.
    cfg(8'hAA, 2'b11);
    idle(1);
    beat(1'b0, 32'h01010101, W'($urandom));
    beat(1'b0, 32'h02020202, W'($urandom));
    beat(1'b1, 32'h04040404, W'($urandom));
    idle(3);

    // OR-reduce frame with a config write landing mid-frame.
    cfg(8'hAA, 2'b10);
    idle(1);
    beat(1'b0, W'($urandom), W'($urandom));
    cyc(1'b1, 1'b1, 8'h88, 2'b01, 1'b1, 1'b0, W'($urandom), W'($urandom), W'($urandom));
    beat(1'b0, W'($urandom), W'($urandom));
    beat(1'b1, W'($urandom), W'($urandom));
    beat(1'b0, W'($urandom), W'($urandom));
    beat(1'b1, W'($urandom), W'($urandom));
    idle(3);

    // Clock-enable freeze with beats in flight.
    cfg(8'hE8, 2'b00);
    idle(1);
    beat(1'b0, W'($urandom), W'($urandom));
    beat(1'b0, W'($urandom), W'($urandom));
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 8'($urandom), 2'($urandom), 1'b1, 1'($urandom),
          W'($urandom), W'($urandom), W'($urandom));
    beat(1'b1, W'($urandom), W'($urandom));
    idle(3);

    // Asynchronous reset mid-frame with a config pending and a beat on the output.
    beat(1'b0, W'($urandom), W'($urandom));
    cfg(8'h88, 2'b11);
    mid_reset();
    beat(1'b1, W'($urandom), W'($urandom));
    idle(3);

    // Randomized traffic, config writes and clock-enable gaps.
    for (int i = 0; i < 600; i++)
      cyc(($urandom % 10) != 0, ($urandom % 12) == 0, 8'($urandom), 2'($urandom),
          ($urandom % 3) != 0, ($urandom % 4) == 0,
          W'($urandom), W'($urandom), W'($urandom));

    cke = 1'b1;
    idle(LATENCY + 4);
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
